// File: rtl/conv_window_loader.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_loader
// Description : Tracks the convolution output position, latches the 3x3
//               window base address and fetches the nine window pixels from
//               a one-cycle-latency feature-map memory into three row regs.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_loader #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int ADDR_W = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  addr_gen,
   input  logic                  load,
   input  logic                  counter_enable,
   output logic                  mem_rd_en,
   output logic [ADDR_W-1:0]     mem_addr,
   input  logic [DATA_W-1:0]     mem_rd_data,
   output logic [3*DATA_W-1:0]   row0,
   output logic [3*DATA_W-1:0]   row1,
   output logic [3*DATA_W-1:0]   row2,
   output logic                  load_done,
   output logic                  done,
   output logic [ADDR_W-1:0]     out_row,
   output logic [ADDR_W-1:0]     out_col
);

   localparam logic [ADDR_W-1:0] c_img_w    = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] c_col_last = ADDR_W'(IMG_W - 3);
   localparam logic [ADDR_W-1:0] c_row_last = ADDR_W'(IMG_H - 3);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      READY = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            idx_q, idx_d;
   logic [ADDR_W-1:0]     base_q, base_d;
   logic [ADDR_W-1:0]     out_row_q, out_row_d;
   logic [ADDR_W-1:0]     out_col_q, out_col_d;
   logic                  done_q, done_d;
   logic                  load_done_q, load_done_d;
   logic                  cap_vld_q, cap_vld_d;
   logic [3:0]            cap_idx_q, cap_idx_d;
   logic [3*DATA_W-1:0]   rows_q [3];
   logic [3*DATA_W-1:0]   rows_d [3];

   logic                  rd_en;
   logic [3:0]            fetch_rc;
   logic [3:0]            cap_rc;

   // Split a window index 0..8 into {row[1:0], col[1:0]}.
   function automatic logic [3:0] idx_to_rc(input logic [3:0] idx);
      case (idx)
         4'd0:    return 4'b00_00;
         4'd1:    return 4'b00_01;
         4'd2:    return 4'b00_10;
         4'd3:    return 4'b01_00;
         4'd4:    return 4'b01_01;
         4'd5:    return 4'b01_10;
         4'd6:    return 4'b10_00;
         4'd7:    return 4'b10_01;
         4'd8:    return 4'b10_10;
         default: return 4'b00_00;
      endcase
   endfunction

   assign fetch_rc = idx_to_rc(idx_q);
   assign cap_rc   = idx_to_rc(cap_idx_q);

   // A new base latch wins over an outstanding read request in the same cycle.
   assign rd_en     = (state_q == FETCH) && load && !addr_gen;
   assign mem_rd_en = rd_en;
   assign mem_addr  = rd_en ? (base_q + ADDR_W'(fetch_rc[3:2]) * c_img_w + ADDR_W'(fetch_rc[1:0]))
                            : '0;

   assign row0      = rows_q[0];
   assign row1      = rows_q[1];
   assign row2      = rows_q[2];
   assign load_done = load_done_q;
   assign done      = done_q;
   assign out_row   = out_row_q;
   assign out_col   = out_col_q;

   // Next-state: fetch sequencing, pixel capture, base latch and position counters.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      base_d      = base_q;
      out_row_d   = out_row_q;
      out_col_d   = out_col_q;
      done_d      = done_q;
      load_done_d = load_done_q;
      rows_d      = rows_q;
      cap_vld_d   = rd_en;
      cap_idx_d   = idx_q;

      case (state_q)
         IDLE: begin
            if (load) state_d = FETCH;
         end
         FETCH: begin
            if (rd_en) begin
               idx_d = idx_q + 4'd1;
               if (idx_q == 4'd8) state_d = DRAIN;
            end
         end
         DRAIN: begin
            load_done_d = 1'b1;
            state_d     = READY;
         end
         READY: begin
            state_d = READY;
         end
         default: state_d = IDLE;
      endcase

      // Data returns one cycle after its read; the delayed index steers it.
      if (cap_vld_q) begin
         rows_d[cap_rc[3:2]][cap_rc[1:0]*DATA_W +: DATA_W] = mem_rd_data;
      end

      // Base uses the counter values before any same-cycle advance.
      if (addr_gen) begin
         base_d      = out_row_q * c_img_w + out_col_q;
         idx_d       = 4'd0;
         load_done_d = 1'b0;
         done_d      = 1'b0;
         state_d     = IDLE;
      end

      if (counter_enable) begin
         if (out_col_q < c_col_last) begin
            out_col_d = out_col_q + 1'b1;
         end else begin
            out_col_d = '0;
            if (out_row_q < c_row_last) begin
               out_row_d = out_row_q + 1'b1;
            end else begin
               out_row_d = '0;
               done_d    = 1'b1;
            end
         end
      end
   end

   // State registers; reset also drops any read still in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         base_q      <= '0;
         out_row_q   <= '0;
         out_col_q   <= '0;
         done_q      <= 1'b0;
         load_done_q <= 1'b0;
         cap_vld_q   <= 1'b0;
         cap_idx_q   <= '0;
         rows_q[0]   <= '0;
         rows_q[1]   <= '0;
         rows_q[2]   <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         base_q      <= base_d;
         out_row_q   <= out_row_d;
         out_col_q   <= out_col_d;
         done_q      <= done_d;
         load_done_q <= load_done_d;
         cap_vld_q   <= cap_vld_d;
         cap_idx_q   <= cap_idx_d;
         rows_q[0]   <= rows_d[0];
         rows_q[1]   <= rows_d[1];
         rows_q[2]   <= rows_d[2];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_window_loader
// Description : Self-checking bench for conv_window_loader: directed window
//               table, reset / wrap sequences and randomized windows against
//               a position/memory reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_loader;

   localparam int DATA_W = 8;
   localparam int IMG_W  = 5;
   localparam int IMG_H  = 4;
   localparam int ADDR_W = 10;
   localparam int NCOL   = IMG_W - 2;
   localparam int NPOS   = NCOL * (IMG_H - 2);

   logic                clk = 1'b0;
   logic                rst_n;
   logic                addr_gen;
   logic                load;
   logic                counter_enable;
   logic                mem_rd_en;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_rd_data;
   logic [3*DATA_W-1:0] row0, row1, row2;
   logic                load_done;
   logic                done;
   logic [ADDR_W-1:0]   out_row, out_col;

   logic [DATA_W-1:0]   mem [0:IMG_W*IMG_H-1];

   int n_vec = 0;
   int n_err = 0;
   int mpos  = 0;
   bit mdone = 1'b0;

   typedef struct {
      int           n_ce;
      int           k;
      int           g;
      int           hold;
      logic [23:0]  r0;
      logic [23:0]  r1;
      logic [23:0]  r2;
   } vec_t;

   vec_t tbl [5];

   conv_window_loader #(
      .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .addr_gen       (addr_gen),
      .load           (load),
      .counter_enable (counter_enable),
      .mem_rd_en      (mem_rd_en),
      .mem_addr       (mem_addr),
      .mem_rd_data    (mem_rd_data),
      .row0           (row0),
      .row1           (row1),
      .row2           (row2),
      .load_done      (load_done),
      .done           (done),
      .out_row        (out_row),
      .out_col        (out_col)
   );

   always #5 clk = ~clk;

   // Feature-map memory with one-cycle read latency.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_addr];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic int cur_base();
      return (mpos / NCOL) * IMG_W + (mpos % NCOL);
   endfunction

   function automatic logic [23:0] exp_row(input int base, input int r);
      return {mem[base + r*IMG_W + 2], mem[base + r*IMG_W + 1], mem[base + r*IMG_W]};
   endfunction

   task automatic check_pos();
      chk("out_row", 32'(out_row), 32'(mpos / NCOL));
      chk("out_col", 32'(out_col), 32'(mpos % NCOL));
      chk("done",    32'(done),    32'(mdone));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_rd_en"},     32'(mem_rd_en), 32'd0);
      chk({tag, "_addr"},      32'(mem_addr),  32'd0);
      chk({tag, "_row0"},      32'(row0),      32'd0);
      chk({tag, "_row1"},      32'(row1),      32'd0);
      chk({tag, "_row2"},      32'(row2),      32'd0);
      chk({tag, "_load_done"}, 32'(load_done), 32'd0);
      chk({tag, "_done"},      32'(done),      32'd0);
      chk({tag, "_out_row"},   32'(out_row),   32'd0);
      chk({tag, "_out_col"},   32'(out_col),   32'd0);
   endtask

   task automatic advance_model();
      mpos = (mpos + 1) % NPOS;
      if (mpos == 0) mdone = 1'b1;
   endtask

   task automatic pulse_ce();
      counter_enable = 1'b1;
      step();
      counter_enable = 1'b0;
      advance_model();
      @(negedge clk);
      check_pos();
      step();
   endtask

   // One window: addr_gen, then load high except for g low cycles after k reads.
   task automatic run_window(input int k, input int g, input int hold, input bit ce_ag,
                             input logic [23:0] e0, input logic [23:0] e1, input logic [23:0] e2);
      int base;
      int lat;
      int issued;
      bit ld;
      bit exp_rd;
      base   = cur_base();
      lat    = 11 + ((k < 9) ? g : 0);
      issued = 0;
      addr_gen       = 1'b1;
      counter_enable = ce_ag;
      step();
      addr_gen       = 1'b0;
      counter_enable = 1'b0;
      mdone = 1'b0;
      if (ce_ag) advance_model();
      for (int n = 0; n <= lat + 1; n++) begin
         ld   = (n <= k) || (n > k + g);
         load = ld;
         @(negedge clk);
         exp_rd = (n >= 1) && ld && (issued < 9);
         chk("rd_en", 32'(mem_rd_en), 32'(exp_rd));
         if (exp_rd) begin
            chk("rd_addr", 32'(mem_addr), 32'(base + (issued / 3) * IMG_W + issued % 3));
            issued++;
         end
         chk("load_done", 32'(load_done), 32'(n >= lat));
         if (n == 0) check_pos();
         step();
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_rd_en",     32'(mem_rd_en), 32'd0);
         chk("hold_load_done", 32'(load_done), 32'd1);
         chk("row0", 32'(row0), 32'(e0));
         chk("row1", 32'(row1), 32'(e1));
         chk("row2", 32'(row2), 32'(e2));
         step();
      end
      load = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int base;
      int npulse;
      int k;
      int g;
      bit ce_ag;

      tbl[0] = '{0, 9, 0, 10, 24'h020100, 24'h070605, 24'h0C0B0A};
      tbl[1] = '{5, 9, 0, 2,  24'h090807, 24'h0E0D0C, 24'h131211};
      tbl[2] = '{1, 4, 2, 2,  24'h020100, 24'h070605, 24'h0C0B0A};
      tbl[3] = '{4, 0, 3, 2,  24'h080706, 24'h0D0C0B, 24'h121110};
      tbl[4] = '{1, 8, 1, 2,  24'h090807, 24'h0E0D0C, 24'h131211};

      for (int a = 0; a < IMG_W*IMG_H; a++) mem[a] = DATA_W'(a);

      rst_n = 1'b0; addr_gen = 1'b0; load = 1'b0; counter_enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_zero("reset");
      step();

      // Directed window table.
      for (int i = 0; i < 5; i++) begin
         repeat (tbl[i].n_ce) pulse_ce();
         run_window(tbl[i].k, tbl[i].g, tbl[i].hold, 1'b0, tbl[i].r0, tbl[i].r1, tbl[i].r2);
      end

      // Reset in cycle 5 of a fetch: read in flight must be dropped.
      addr_gen = 1'b1;
      step();
      addr_gen = 1'b0;
      load = 1'b1;
      repeat (5) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      load  = 1'b0;
      mpos  = 0;
      mdone = 1'b0;
      @(negedge clk);
      check_zero("midreset");
      step();
      @(negedge clk);
      check_zero("latedata");
      step();

      // Full sweep of the six positions: done on the wrap, cleared by addr_gen.
      repeat (NPOS) pulse_ce();
      run_window(9, 0, 2, 1'b0, 24'h020100, 24'h070605, 24'h0C0B0A);

      // Randomized windows with random memory contents.
      for (int i = 0; i < 20; i++) begin
         for (int a = 0; a < IMG_W*IMG_H; a++) mem[a] = DATA_W'($urandom);
         npulse = $urandom_range(0, 7);
         repeat (npulse) pulse_ce();
         k     = $urandom_range(0, 9);
         g     = $urandom_range(0, 3);
         ce_ag = ($urandom_range(0, 1) == 1) && (mpos != NPOS - 1);
         base  = cur_base();
         run_window(k, g, 2, ce_ag, exp_row(base, 0), exp_row(base, 1), exp_row(base, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
